pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the instruction-fetch stage. Produces the fetch address and chip-enable for instruction memory, advances sequentially on each accepted fetch, and redirects on branch/jump or pipeline flush (exception entry/return). It replaces the fixed 32-bit, always-advance PC register: adds reset vector, stall and memory-grant back-pressure, and capture of branch requests that arrive while the fetch is held.

## Interface
Parameters:
- ADDR_W, 32, PC width in bits
- INST_BYTES, 4, sequential increment; power of two, ≥1
- RESET_VEC, 32'h0000_0000, PC value loaded on reset (ADDR_W bits)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall_i  in  1  IF stage stall from pipeline control; holds PC
- flush_i  in  1  flush/redirect request (exception, eret)
- flush_pc_i  in  ADDR_W  flush target
- br_valid_i  in  1  branch/jump taken, one-cycle pulse
- br_target_i  in  ADDR_W  branch target
- imem_gnt_i  in  1  instruction memory accepted fetch at pc_o this cycle
- pc_o  out  ADDR_W  current fetch address (registered)
- ce_o  out  1  instruction memory chip enable (registered)
- br_pend_o  out  1  a captured branch is waiting to be applied
- misalign_o  out  1  pc_o not aligned to INST_BYTES (see Configuration)

## Operation
- States: BOOT, RUN.
- rst=1 (any state, any cycle): state←BOOT, pc_o←RESET_VEC, ce_o←0, br_pend_o←0, pend_pc←0, misalign_o←0. Reset overrides every other input.
- BOOT, rst=0: state←RUN, ce_o←1, pc_o unchanged (RESET_VEC). Other inputs ignored in BOOT.
- RUN: advance = ce_o & imem_gnt_i & ~stall_i. Priority, first match wins:
  1. flush_i: pc_o←flush_pc_i, ce_o←1, br_pend_o←0; br_valid_i same cycle discarded. Applies regardless of stall/grant.
  2. advance & br_valid_i: pc_o←br_target_i, br_pend_o←0 (fresh branch supersedes pending one).
  3. advance & br_pend_o: pc_o←pend_pc, br_pend_o←0.
  4. advance: pc_o←pc_o+INST_BYTES, modulo 2^ADDR_W (all-ones region wraps to 0, no flag).
  5. ~advance & br_valid_i: pend_pc←br_target_i, br_pend_o←1 (overwrites an older pending target); pc_o held.
  6. otherwise hold all state.
- ce_o stays 1 throughout RUN; only reset/BOOT deasserts it.
- pc_o must stay stable while ce_o=1 and imem_gnt_i=0.

## Timing
- All outputs registered; any redirect or increment visible on pc_o the cycle after the triggering edge.
- First fetch: rst falls at edge N → ce_o=1 with pc_o=RESET_VEC after edge N+1.
- Pending branch released on the first advance cycle; next PC = pend_pc one cycle later.
- Stall and grant-low are equivalent for holding; no combinational path from any input to any output.

## Configuration
- PC_MISALIGN_CHK_EN defined: misalign_o registered alongside pc_o, set when a loaded target (flush, branch, pending) has any of the low log2(INST_BYTES) bits nonzero; while misalign_o=1, ce_o←0 (no fetch issued), and only flush_i or rst leaves this condition. Sequential increments preserve alignment.
- Not defined: misalign_o tied 0; targets loaded as given, low bits not checked.

## Structure
- Shared package: state encoding (BOOT/RUN), default INST_BYTES, reset-vector constant, chip enable/disable constants.
- Single module; no sub-module. Pending-branch register kept inline with PC register.

## Test plan
- Reset then release: rst high 3 cycles, low → cycle 1 ce_o=0 pc_o=0, cycle 2 ce_o=1 pc_o=0, with gnt=1 pc_o 0→4→8→C.
- Grant back-pressure: pc_o=0x10, imem_gnt_i=0 for 3 cycles → pc_o holds 0x10, then 0x14 after grant.
- Branch under stall: stall_i=1, br_valid_i pulse target 0x200 → br_pend_o=1, pc_o held; stall drops → pc_o=0x200, br_pend_o=0.
- Flush beats branch: flush_i with 0x180 and br_valid_i with 0x200 same cycle, stalled, pending 0x300 → pc_o=0x180, br_pend_o=0.
- Wrap: ADDR_W=8, pc_o=0xFC, advance → pc_o=0x00.
- PC_MISALIGN_CHK_EN: branch to 0x102 → misalign_o=1, ce_o=0; flush to 0x400 → misalign_o=0, ce_o=1.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared constants for the instruction-fetch program-counter generator:
// state encoding, default increment, reset vector and chip-enable levels.
package pc_gen_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } pc_state_e;

  localparam int          DEF_INST_BYTES = 4;
  localparam logic [31:0] DEF_RESET_VEC  = 32'h0000_0000;
  localparam logic        CE_ON          = 1'b1;
  localparam logic        CE_OFF         = 1'b0;

endpackage

// File: rtl/pc_gen.sv
// Program-counter generator: sequential fetch, branch/flush redirect, stall and grant
// back-pressure, branch capture while held. Optional PC_MISALIGN_CHK_EN gates fetch on misaligned targets.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                INST_BYTES = DEF_INST_BYTES,
  parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(DEF_RESET_VEC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              br_valid_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              imem_gnt_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ce_o,
  output logic              br_pend_o,
  output logic              misalign_o
);

`ifdef PC_MISALIGN_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INST_BYTES);

  function automatic logic target_misaligned(input logic [ADDR_W-1:0] addr);
    return CHK_EN && ((addr & ALIGN_MASK) != '0);
  endfunction

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              ce_q, ce_d;
  logic              pend_q, pend_d;
  logic              mis_q, mis_d;
  logic              advance_s;

  assign advance_s = ce_q & imem_gnt_i & ~stall_i;

  // Next-state selection; redirects are prioritised flush > fresh branch > pending > increment.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    ce_d      = ce_q;
    pend_d    = pend_q;
    mis_d     = mis_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        ce_d    = CE_ON;
      end
      RUN: begin
        if (flush_i) begin
          pc_d   = flush_pc_i;
          pend_d = 1'b0;
          mis_d  = target_misaligned(flush_pc_i);
          ce_d   = target_misaligned(flush_pc_i) ? CE_OFF : CE_ON;
        end else if (advance_s && br_valid_i) begin
          pc_d   = br_target_i;
          pend_d = 1'b0;
          mis_d  = target_misaligned(br_target_i);
          ce_d   = target_misaligned(br_target_i) ? CE_OFF : CE_ON;
        end else if (advance_s && pend_q) begin
          pc_d   = pend_pc_q;
          pend_d = 1'b0;
          mis_d  = target_misaligned(pend_pc_q);
          ce_d   = target_misaligned(pend_pc_q) ? CE_OFF : CE_ON;
        end else if (advance_s) begin
          pc_d = pc_q + PC_STEP;
        end else if (br_valid_i) begin
          pend_pc_d = br_target_i;
          pend_d    = 1'b1;
        end else begin
          pc_d = pc_q;
        end
      end
      default: begin
        state_d = BOOT;
        ce_d    = CE_OFF;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BOOT;
      pc_q      <= RESET_VEC;
      pend_pc_q <= '0;
      ce_q      <= CE_OFF;
      pend_q    <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      ce_q      <= ce_d;
      pend_q    <= pend_d;
      mis_q     <= mis_d;
    end
  end

  assign pc_o       = pc_q;
  assign ce_o       = ce_q;
  assign br_pend_o  = pend_q;
  assign misalign_o = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (default 32-bit, 4-byte parameters).
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        br_valid_i;
  logic [31:0] br_target_i;
  logic        imem_gnt_i;
  logic [31:0] pc_o;
  logic        ce_o;
  logic        br_pend_o;
  logic        misalign_o;

  int n_checks = 0;
  int n_fail   = 0;

  pc_gen u_dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .flush_pc_i (flush_pc_i),
    .br_valid_i (br_valid_i),
    .br_target_i(br_target_i),
    .imem_gnt_i (imem_gnt_i),
    .pc_o       (pc_o),
    .ce_o       (ce_o),
    .br_pend_o  (br_pend_o),
    .misalign_o (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] pc, input logic ce, input logic pend);
    check({tag, "_pc"}, pc_o, pc);
    check({tag, "_ce"}, {31'd0, ce_o}, {31'd0, ce});
    check({tag, "_pend"}, {31'd0, br_pend_o}, {31'd0, pend});
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; flush_pc_i = 32'd0;
    br_valid_i = 1'b0; br_target_i = 32'd0; imem_gnt_i = 1'b0;
    repeat (3) tick();
    chk_state("reset", 32'h0, 1'b0, 1'b0);
    check("reset_mis", {31'd0, misalign_o}, 32'd0);

    // Release reset: BOOT cycle, then fetch from the reset vector
    rst = 1'b0; imem_gnt_i = 1'b1;
    tick(); chk_state("boot", 32'h0, 1'b1, 1'b0);
    tick(); check("seq1", pc_o, 32'h4);
    tick(); check("seq2", pc_o, 32'h8);
    tick(); check("seq3", pc_o, 32'hC);
    tick(); check("seq4", pc_o, 32'h10);

    // Grant back-pressure
    imem_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); check("gnt_hold", pc_o, 32'h10);
    end
    check("gnt_hold_ce", {31'd0, ce_o}, 32'd1);
    imem_gnt_i = 1'b1;
    tick(); check("gnt_release", pc_o, 32'h14);

    // Branch captured under stall
    stall_i = 1'b1; br_valid_i = 1'b1; br_target_i = 32'h200;
    tick(); chk_state("br_cap", 32'h14, 1'b1, 1'b1);
    br_valid_i = 1'b0;
    tick(); chk_state("br_wait", 32'h14, 1'b1, 1'b1);
    stall_i = 1'b0;
    tick(); chk_state("br_apply", 32'h200, 1'b1, 1'b0);
    tick(); check("br_after", pc_o, 32'h204);

    // Flush beats branch and pending target
    stall_i = 1'b1; br_valid_i = 1'b1; br_target_i = 32'h300;
    tick(); chk_state("pend300", 32'h204, 1'b1, 1'b1);
    flush_i = 1'b1; flush_pc_i = 32'h180; br_target_i = 32'h200;
    tick(); chk_state("flush", 32'h180, 1'b1, 1'b0);
    flush_i = 1'b0; br_valid_i = 1'b0; stall_i = 1'b0;
    tick(); check("flush_after", pc_o, 32'h184);

    // Wrap at the top of the address space
    flush_i = 1'b1; flush_pc_i = 32'hFFFF_FFFC;
    tick(); check("wrap_top", pc_o, 32'hFFFF_FFFC);
    flush_i = 1'b0;
    tick(); check("wrap_zero", pc_o, 32'h0);
    tick(); check("wrap_next", pc_o, 32'h4);

    // Fresh branch supersedes an older pending one
    stall_i = 1'b1; br_valid_i = 1'b1; br_target_i = 32'h500;
    tick(); check("sup_pend", {31'd0, br_pend_o}, 32'd1);
    stall_i = 1'b0; br_target_i = 32'h600;
    tick(); chk_state("sup_br", 32'h600, 1'b1, 1'b0);
    br_valid_i = 1'b0;
    tick(); check("sup_after", pc_o, 32'h604);

    // Misaligned branch target
    br_valid_i = 1'b1; br_target_i = 32'h102;
    tick(); check("mis_pc", pc_o, 32'h102);
    br_valid_i = 1'b0;
`ifdef PC_MISALIGN_CHK_EN
    check("mis_flag", {31'd0, misalign_o}, 32'd1);
    check("mis_ce", {31'd0, ce_o}, 32'd0);
    tick(); check("mis_hold", pc_o, 32'h102);
    check("mis_stuck", {31'd0, misalign_o}, 32'd1);
`else
    check("mis_flag", {31'd0, misalign_o}, 32'd0);
    check("mis_ce", {31'd0, ce_o}, 32'd1);
    tick(); check("mis_seq", pc_o, 32'h106);
`endif
    flush_i = 1'b1; flush_pc_i = 32'h400;
    tick(); chk_state("mis_clear", 32'h400, 1'b1, 1'b0);
    check("mis_clear_flag", {31'd0, misalign_o}, 32'd0);
    flush_i = 1'b0;

    // Reset mid-run overrides a simultaneous flush
    rst = 1'b1; flush_i = 1'b1; flush_pc_i = 32'h800;
    tick(); chk_state("rst_mid", 32'h0, 1'b0, 1'b0);
    rst = 1'b0; flush_i = 1'b0;
    tick(); chk_state("reboot", 32'h0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
